// File: rtl/button_debouncer_pkg.sv
// Shared types and default constants for the push-button debouncer.
package btn_pkg;

    // Per-channel debounce states: two settled levels and a pending state toward each.
    typedef enum logic [1:0] {
        S_LO,
        S_PEND_HI,
        S_HI,
        S_PEND_LO
    } btn_state_t;

    localparam int BTN_N_DEF            = 5;
    localparam int BTN_TICK_DIV_DEF     = 100000;
    localparam int BTN_STABLE_TICKS_DEF = 10;

    // Width of a counter that must be able to hold the value stable_ticks.
    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle: raw pins in, debounced level and edge strobes out.
interface button_debouncer_if
    import btn_pkg::*;
#(
    parameter int N_BTN = BTN_N_DEF
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;

    // The board side drives raw pins and consumes the conditioned outputs.
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall
    );

    // The debouncer consumes raw pins and produces the conditioned outputs.
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_rise,
        output btn_fall
    );

endinterface

// File: rtl/button_debouncer_ch.sv
// One debounce channel: 2-flop synchroniser, qualification FSM and
// registered level / rise / fall outputs.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = BTN_STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic sync_meta;
    logic sync;

    btn_state_t state;
    btn_state_t state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic level_next;
    logic rise_next;
    logic fall_next;

    // Two plain flops bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // State, tick counter and all outputs are registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // A candidate level must survive STABLE_TICKS ticks; a mismatch aborts
    // before any simultaneous tick is counted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            S_LO: begin
                if (sync) begin
                    state_next = S_PEND_HI;
                    cnt_next   = '0;
                end
            end
            S_PEND_HI: begin
                if (!sync) begin
                    state_next = S_LO;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = S_HI;
                        cnt_next   = '0;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            S_HI: begin
                if (!sync) begin
                    state_next = S_PEND_LO;
                    cnt_next   = '0;
                end
            end
            S_PEND_LO: begin
                if (sync) begin
                    state_next = S_HI;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_next = S_LO;
                        cnt_next   = '0;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_LO;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button conditioner: shared sample-tick generator feeding
// N_BTN independent debounce channels.
module button_debouncer
    import btn_pkg::*;
#(
    parameter int N_BTN        = BTN_N_DEF,
    parameter int TICK_DIV     = BTN_TICK_DIV_DEF,
    parameter int STABLE_TICKS = BTN_STABLE_TICKS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   bus
);

    logic             tick;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] rise_w;
    logic [N_BTN-1:0] fall_w;

    generate
        if (TICK_DIV == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_div
            localparam int DIV_W = $clog2(TICK_DIV);
            localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

            logic [DIV_W-1:0] div_cnt;

            assign tick = (div_cnt == DIV_LAST);

            // Free-running divider; wraps to 0 on the same cycle tick is high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_cnt <= '0;
                end else if (tick) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    endgenerate

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_ch
            btn_debounce_ch #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .raw   (bus.btn_raw[i]),
                .level (level_w[i]),
                .rise  (rise_w[i]),
                .fall  (fall_w[i])
            );
        end
    endgenerate

    assign bus.btn_level = level_w;
    assign bus.btn_rise  = rise_w;
    assign bus.btn_fall  = fall_w;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: two instances (TICK_DIV 4 and 1),
// a run-length reference model pushing expected strobes, and a monitor
// popping and comparing them on the falling clock edge.
module tb_button_debouncer;

    localparam int N    = 2;
    localparam int ST   = 3;
    localparam int TD_A = 4;
    localparam int TD_B = 1;

    typedef struct {
        int ch;
        bit is_rise;
        int edge_idx;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    button_debouncer_if #(.N_BTN(N)) bus_a ();
    button_debouncer_if #(.N_BTN(N)) bus_b ();

    button_debouncer #(
        .N_BTN        (N),
        .TICK_DIV     (TD_A),
        .STABLE_TICKS (ST)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    button_debouncer #(
        .N_BTN        (N),
        .TICK_DIV     (TD_B),
        .STABLE_TICKS (ST)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ev_t exp_qa[$];
    ev_t exp_qb[$];

    bit m_level[2][N];
    bit m_p1[2][N];
    bit m_p2[2][N];
    int m_run[2][N];

    int rise_cnt[2][N];
    int fall_cnt[2][N];
    int last_rise[2][N];
    int last_fall[2][N];

    // Number of tick edges with index in (a, b] for a divider of td.
    function automatic int ticks_in(input int a, input int b, input int td);
        return (b + 1) / td - (a + 1) / td;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [N-1:0] raw);
        if (d == 0) bus_a.btn_raw = raw;
        else        bus_b.btn_raw = raw;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clearStats();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++) begin
                rise_cnt[d][c]  = 0;
                fall_cnt[d][c]  = 0;
                last_rise[d][c] = -1000;
                last_fall[d][c] = -1000;
            end
        end
    endtask

    // Reference model: a new level is accepted on the tick that makes the
    // number of ticks since its disagreement run began equal ST.
    initial begin
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < N; c++) m_run[d][c] = -1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < N; c++) begin
                        m_level[d][c] = 1'b0;
                        m_p1[d][c]    = 1'b0;
                        m_p2[d][c]    = 1'b0;
                        m_run[d][c]   = -1;
                    end
                end
                exp_qa.delete();
                exp_qb.delete();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    int td;
                    bit tick_now;
                    logic [N-1:0] raw;
                    td = (d == 0) ? TD_A : TD_B;
                    tick_now = ((cyc % td) == td - 1);
                    raw = (d == 0) ? bus_a.btn_raw : bus_b.btn_raw;
                    for (int c = 0; c < N; c++) begin
                        bit x;
                        ev_t ev;
                        x = m_p2[d][c];
                        m_p2[d][c] = m_p1[d][c];
                        m_p1[d][c] = raw[c];
                        if (x == m_level[d][c]) begin
                            m_run[d][c] = -1;
                        end else if (m_run[d][c] < 0) begin
                            m_run[d][c] = cyc;
                        end else if (tick_now && ticks_in(m_run[d][c], cyc, td) == ST) begin
                            m_level[d][c] = x;
                            m_run[d][c]   = -1;
                            ev.ch       = c;
                            ev.is_rise  = x;
                            ev.edge_idx = cyc;
                            if (d == 0) exp_qa.push_back(ev);
                            else        exp_qb.push_back(ev);
                        end
                    end
                end
                cyc = cyc + 1;
            end
        end
    end

    // Monitor: compares levels every cycle and pops one expected event per strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("reset_outputs_a", int'({bus_a.btn_level, bus_a.btn_rise, bus_a.btn_fall}), 0);
                checkOutput("reset_outputs_b", int'({bus_b.btn_level, bus_b.btn_rise, bus_b.btn_fall}), 0);
            end else begin
                for (int d = 0; d < 2; d++) begin
                    logic [N-1:0] lv;
                    logic [N-1:0] rs;
                    logic [N-1:0] fl;
                    ev_t ev;
                    lv = (d == 0) ? bus_a.btn_level : bus_b.btn_level;
                    rs = (d == 0) ? bus_a.btn_rise  : bus_b.btn_rise;
                    fl = (d == 0) ? bus_a.btn_fall  : bus_b.btn_fall;
                    for (int c = 0; c < N; c++) begin
                        checks++;
                        if (lv[c] != m_level[d][c]) begin
                            failures++;
                            $display("[TB] FAIL level d%0d ch%0d @%0d: got %0b expected %0b",
                                     d, c, cyc - 1, lv[c], m_level[d][c]);
                        end
                        if (rs[c] || fl[c]) begin
                            bit ok;
                            int qsz;
                            qsz = (d == 0) ? exp_qa.size() : exp_qb.size();
                            ok = 1'b0;
                            if (qsz > 0) begin
                                ev = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                                ok = (ev.ch == c) && (ev.is_rise == rs[c]) && (ev.is_rise != fl[c])
                                     && (ev.edge_idx == cyc - 1);
                            end
                            checks++;
                            if (!ok) begin
                                failures++;
                                $display("[TB] FAIL strobe d%0d ch%0d @%0d: got rise=%0b fall=%0b, queued=%0d",
                                         d, c, cyc - 1, rs[c], fl[c], qsz);
                            end
                            if (rs[c]) begin
                                rise_cnt[d][c]++;
                                last_rise[d][c] = cyc - 1;
                            end
                            if (fl[c]) begin
                                fall_cnt[d][c]++;
                                last_fall[d][c] = cyc - 1;
                            end
                        end
                    end
                    // Any expected strobe older than this cycle was missed.
                    forever begin
                        int qsz;
                        qsz = (d == 0) ? exp_qa.size() : exp_qb.size();
                        if (qsz == 0) break;
                        ev = (d == 0) ? exp_qa[0] : exp_qb[0];
                        if (ev.edge_idx >= cyc - 1) break;
                        if (d == 0) void'(exp_qa.pop_front());
                        else        void'(exp_qb.pop_front());
                        checks++;
                        failures++;
                        $display("[TB] FAIL missed_strobe d%0d ch%0d: got none expected at edge %0d",
                                 d, ev.ch, ev.edge_idx);
                    end
                end
            end
        end
    end

    initial begin
        int p;
        int p0;
        int p1;
        logic b;

        clearStats();
        bus_a.btn_raw = '0;
        bus_b.btn_raw = '0;

        // Reset held with both buttons pressed, then release.
        applyStimulus(0, 2'b11);
        rst_n = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(20);
        checkOutput("reset_rise_count_ch0", rise_cnt[0][0], 1);
        checkOutput("reset_rise_count_ch1", rise_cnt[0][1], 1);
        checkOutput("reset_level", int'(bus_a.btn_level), 3);
        checkRange("reset_latency_ch0", last_rise[0][0] + 1, 11, 15);
        applyStimulus(0, 2'b00);
        step(20);

        // Clean press and release on channel 0.
        clearStats();
        p = cyc;
        applyStimulus(0, 2'b01);
        step(30);
        checkRange("press_latency", last_rise[0][0] - (p - 1), 12, 15);
        checkOutput("press_rise_count", rise_cnt[0][0], 1);
        step(10);
        p = cyc;
        applyStimulus(0, 2'b00);
        step(20);
        checkRange("release_latency", last_fall[0][0] - (p - 1), 12, 15);
        checkOutput("release_fall_count", fall_cnt[0][0], 1);
        checkOutput("ch1_quiet_rise", rise_cnt[0][1], 0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold pressed.
        clearStats();
        b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, {1'b0, b});
            step(3);
            b = ~b;
        end
        checkOutput("bounce_no_rise", rise_cnt[0][0], 0);
        p = cyc;
        applyStimulus(0, 2'b01);
        step(25);
        checkOutput("bounce_one_rise", rise_cnt[0][0], 1);
        checkRange("bounce_latency", last_rise[0][0] - (p - 1), 1, 15);
        applyStimulus(0, 2'b00);
        step(25);

        // Short glitch must not qualify.
        clearStats();
        applyStimulus(0, 2'b01);
        step(6);
        applyStimulus(0, 2'b00);
        step(25);
        checkOutput("glitch_rise", rise_cnt[0][0], 0);
        checkOutput("glitch_fall", fall_cnt[0][0], 0);

        // Reset during a pending press, then re-qualification from scratch.
        clearStats();
        applyStimulus(0, 2'b01);
        step(8);
        rst_n = 1'b0;
        step(3);
        checkOutput("midreset_no_rise", rise_cnt[0][0], 0);
        rst_n = 1'b1;
        step(20);
        checkRange("midreset_requalify", last_rise[0][0] + 1, 11, 15);
        applyStimulus(0, 2'b00);
        step(25);

        // Independence with TICK_DIV = 1: presses one cycle apart.
        clearStats();
        p0 = cyc;
        applyStimulus(1, 2'b01);
        step(1);
        p1 = cyc;
        applyStimulus(1, 2'b11);
        step(15);
        checkOutput("indep_latency_ch0", last_rise[1][0] - (p0 - 1), 6);
        checkOutput("indep_latency_ch1", last_rise[1][1] - (p1 - 1), 6);
        checkOutput("indep_strobe_gap", last_rise[1][1] - last_rise[1][0], 1);
        applyStimulus(1, 2'b00);
        step(15);

        // Randomised holds on both instances with occasional resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, N'($urandom));
            applyStimulus(1, N'($urandom));
            step($urandom_range(1, 20));
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                step(2);
                rst_n = 1'b1;
            end
        end
        applyStimulus(0, 2'b00);
        applyStimulus(1, 2'b00);
        step(40);
        checkOutput("final_queue_a", exp_qa.size(), 0);
        checkOutput("final_queue_b", exp_qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
